// File: rtl/muldiv_ctrl_if.sv
// Operand/result bundle for muldiv_ctrl (RISC-V M-extension multiply/divide unit).
// Handshake: start is a request pulse taken only while busy=0; valid is a one-cycle result strobe.
interface muldiv_ctrl_if;
   logic        start;
   logic [31:0] data1;
   logic [31:0] data2;
   logic [2:0]  select;
   logic        flush;
   logic        busy;
   logic        valid;
   logic [31:0] result;

   modport master (
      output start, data1, data2, select, flush,
      input  busy, valid, result
   );

   modport slave (
      input  start, data1, data2, select, flush,
      output busy, valid, result
   );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative radix-2 RISC-V M-extension multiply/divide controller.
// Optional macro MULDIV_FASTPATH_EN: trivial cases (div by zero, overflow, multiply by zero) finish directly.
module muldiv_ctrl (
   input  logic         clk,
   input  logic         reset_n,
   muldiv_ctrl_if.slave bus,
   output logic [1:0]   dbg_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

   state_t      state;
   logic [5:0]  cnt;
   logic [63:0] prod;
   logic [31:0] quot;
   logic [31:0] rem;
   logic [31:0] mag1;
   logic [31:0] mag2;
   logic        sign1;
   logic        sign2;
   logic [2:0]  op;
   logic        busy_q;
   logic        valid_q;
   logic [31:0] result_q;

   logic        cap_s1;
   logic        cap_s2;
   logic [31:0] cap_m1;
   logic [31:0] cap_m2;
   logic [32:0] mul_sum;
   logic [63:0] prod_nxt;
   logic [32:0] div_shift;
   logic        div_ge;
   logic [31:0] div_diff;
   logic [31:0] quot_nxt;
   logic [31:0] rem_nxt;
   logic [63:0] prod_fix;
   logic [31:0] quot_fix;
   logic [31:0] rem_fix;
   logic [31:0] final_res;
   logic        fast_hit;
   logic [31:0] fast_res;

   assign bus.busy   = busy_q;
   assign bus.valid  = valid_q;
   assign bus.result = result_q;
   assign dbg_state  = state;

   // Operands are reduced to magnitudes at capture; signs are reapplied on the final iteration.
   always_comb begin
      cap_s1 = 1'b0;
      cap_s2 = 1'b0;
      case (bus.select)
         3'b001, 3'b100, 3'b110: begin
            cap_s1 = bus.data1[31];
            cap_s2 = bus.data2[31];
         end
         3'b010:  cap_s1 = bus.data1[31];
         default: ;
      endcase
      cap_m1 = cap_s1 ? -bus.data1 : bus.data1;
      cap_m2 = cap_s2 ? -bus.data2 : bus.data2;
   end

   always_comb begin
      mul_sum   = {1'b0, prod[63:32]} + {1'b0, (prod[0] ? mag1 : 32'd0)};
      prod_nxt  = {mul_sum, prod[31:1]};
      div_shift = {rem, quot[31]};
      div_ge    = (div_shift >= {1'b0, mag2});
      div_diff  = div_shift[31:0] - mag2;
      quot_nxt  = {quot[30:0], div_ge};
      rem_nxt   = div_ge ? div_diff : div_shift[31:0];
      prod_fix  = (sign1 ^ sign2) ? -prod_nxt : prod_nxt;
      // With a zero divisor the restoring loop leaves rem = |DATA1|, so only the quotient needs overriding.
      quot_fix  = (mag2 == 32'd0) ? 32'hFFFF_FFFF : ((sign1 ^ sign2) ? -quot_nxt : quot_nxt);
      rem_fix   = sign1 ? -rem_nxt : rem_nxt;
      case (op)
         3'b000:                 final_res = prod_fix[31:0];
         3'b001, 3'b010, 3'b011: final_res = prod_fix[63:32];
         3'b100, 3'b101:         final_res = quot_fix;
         default:                final_res = rem_fix;
      endcase
   end

   always_comb begin
      fast_hit = 1'b0;
      fast_res = 32'd0;
`ifdef MULDIV_FASTPATH_EN
      if (bus.select[2]) begin
         if (bus.data2 == 32'd0) begin
            fast_hit = 1'b1;
            fast_res = bus.select[1] ? bus.data1 : 32'hFFFF_FFFF;
         end else if (!bus.select[0] && bus.data1 == 32'h8000_0000 &&
                      bus.data2 == 32'hFFFF_FFFF) begin
            fast_hit = 1'b1;
            fast_res = bus.select[1] ? 32'd0 : 32'h8000_0000;
         end
      end else if (bus.data1 == 32'd0 || bus.data2 == 32'd0) begin
         fast_hit = 1'b1;
         fast_res = 32'd0;
      end
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         cnt      <= 6'd0;
         prod     <= 64'd0;
         quot     <= 32'd0;
         rem      <= 32'd0;
         mag1     <= 32'd0;
         mag2     <= 32'd0;
         sign1    <= 1'b0;
         sign2    <= 1'b0;
         op       <= 3'd0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         result_q <= 32'd0;
      end else if (bus.flush) begin
         state   <= IDLE;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  mag1   <= cap_m1;
                  mag2   <= cap_m2;
                  sign1  <= cap_s1;
                  sign2  <= cap_s2;
                  op     <= bus.select;
                  cnt    <= 6'd0;
                  prod   <= {32'd0, cap_m2};
                  quot   <= cap_m1;
                  rem    <= 32'd0;
                  busy_q <= 1'b1;
                  if (fast_hit) begin
                     state    <= DONE;
                     valid_q  <= 1'b1;
                     result_q <= fast_res;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               cnt <= cnt + 6'd1;
               if (op[2]) begin
                  quot <= quot_nxt;
                  rem  <= rem_nxt;
               end else begin
                  prod <= prod_nxt;
               end
               if (cnt == 6'd31) begin
                  state    <= DONE;
                  valid_q  <= 1'b1;
                  result_q <= final_res;
               end
            end
            DONE: begin
               state   <= IDLE;
               busy_q  <= 1'b0;
               valid_q <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               busy_q  <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have port CLK, input, 1 bit: the single clock, rising-edge active.
REQ-002 SHALL have port RESET_N, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port START, input, 1 bit: operation request, sampled at a rising edge.
REQ-004 SHALL have port DATA1, input, 32 bits: rs1 operand (dividend or multiplicand).
REQ-005 SHALL have port DATA2, input, 32 bits: rs2 operand (divisor or multiplier).
REQ-006 SHALL have port SELECT, input, 3 bits: RISC-V M funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-007 SHALL have port FLUSH, input, 1 bit: abort the in-flight operation.
REQ-008 SHALL have port BUSY, output, 1 bit: high when state is not IDLE; used as the pipeline stall.
REQ-009 SHALL have port VALID, output, 1 bit: one-cycle result strobe.
REQ-010 SHALL have port RESULT, output, 32 bits: registered result, held until the next VALID.

Function
REQ-011 SHALL implement FSM states IDLE, CALC and DONE; BUSY = (state != IDLE); VALID = (state == DONE).
REQ-012 SHALL, in IDLE with START=1 and FLUSH=0 at edge N, capture operand magnitudes, operand signs, SELECT, and clear the 6-bit iteration counter, then enter CALC.
REQ-013 SHALL ignore START while in CALC or DONE, with no queueing and no operand capture.
REQ-014 SHALL perform one radix-2 iteration per CLK edge in CALC: shift-add for multiply on a 64-bit unsigned product, restoring shift-subtract for divide on a 32-bit quotient and 32-bit remainder.
REQ-015 SHALL leave CALC after 32 iterations (edges N+1..N+32) and enter DONE, so that VALID is high in the cycle following edge N+32.
REQ-016 SHALL transition from DONE to IDLE unconditionally on the next edge; a new START is accepted from IDLE only.
REQ-017 SHALL select RESULT as follows: MUL = product[31:0]; MULH, MULHSU and MULHU = product[63:32] after sign correction.
REQ-018 SHALL select RESULT as follows: DIV and DIVU = quotient; REM and REMU = remainder.
REQ-019 SHALL apply signedness by SELECT: MULH, DIV and REM treat both operands as signed; MULHSU treats DATA1 as signed and DATA2 as unsigned; the rest are unsigned.
REQ-020 SHALL negate the 64-bit product when the operand signs differ; SHALL give the quotient sign = sign1 XOR sign2; SHALL give the remainder the sign of DATA1.
REQ-021 SHALL, on divide by zero, return quotient 32'hFFFFFFFF and remainder = DATA1 for both signed and unsigned operations.
REQ-022 SHALL, on signed overflow (DIV or REM with DATA1=32'h80000000 and DATA2=32'hFFFFFFFF), return quotient 32'h80000000 and remainder 0.
REQ-023 SHALL, on FLUSH=1 at any edge, enter IDLE; a flushed operation SHALL never raise VALID, and RESULT SHALL keep its prior value.
REQ-024 SHALL give FLUSH priority over START when both are high in the same IDLE edge: no capture occurs.
REQ-025 SHALL hold RESULT stable from the DONE edge until the next DONE edge.

Reset
REQ-026 SHALL, while RESET_N=0, asynchronously force state IDLE, BUSY=0, VALID=0, RESULT=0, counter=0, product, quotient and remainder registers to 0.
REQ-027 SHALL, when reset is asserted during CALC, abandon the operation with no VALID after release.
REQ-028 SHALL resume normal operation at the first rising edge after RESET_N returns high.

Configuration
REQ-029 SHALL, with macro MULDIV_FASTPATH_EN defined, route divide-by-zero, signed overflow, and any multiply with an operand equal to 0 from IDLE directly to DONE, giving VALID in the cycle after the START edge.
REQ-030 SHALL, without MULDIV_FASTPATH_EN, run every operation the full 32 iterations, with results identical to those of REQ-017 to REQ-022.

Verification
REQ-031 SHALL cover MUL: DATA1=7, DATA2=-3 (32'hFFFFFFFD) -> RESULT=32'hFFFFFFEB, VALID exactly 32 cycles after the START edge, BUSY high for 33 cycles.
REQ-032 SHALL cover MULHU: DATA1=DATA2=32'hFFFFFFFF -> RESULT=32'hFFFFFFFE; MULH with the same operands -> 0.
REQ-033 SHALL cover DIV -20/3 -> RESULT=-6 (32'hFFFFFFFA); REM -20/3 -> RESULT=-2 (32'hFFFFFFFE); DIVU 20/0 -> 32'hFFFFFFFF.
REQ-034 SHALL cover DIV 32'h80000000 / 32'hFFFFFFFF -> 32'h80000000 and REM -> 0, with one-cycle latency when MULDIV_FASTPATH_EN is defined and 32-cycle latency otherwise.
REQ-035 SHALL cover FLUSH asserted at iteration 10 of DIVU 100/7 -> IDLE on the next edge, no VALID, RESULT unchanged; an immediately following DIVU 100/7 -> RESULT=14.
REQ-036 SHALL cover a second START pulsed during CALC (ignored, only one VALID) and RESET_N pulsed low mid-CALC (outputs 0 immediately, no VALID after release).
